// File: rtl/seq_mux_if.sv
// Handshake bundle for seq_mux: channel data and select controls in, registered sample out.
interface seq_mux_if #(
  parameter int DATA_W = 1,
  parameter int N_CH   = 16,
  parameter int SEL_W  = 4
);
  logic [N_CH*DATA_W-1:0] d;
  logic [SEL_W-1:0]       sel;
  logic                   sel_load;
  logic                   mode;
  logic                   en;
  logic [DATA_W-1:0]      y;
  logic [SEL_W-1:0]       y_ch;
  logic                   y_last;
  logic                   y_valid;
  logic                   y_ready;

  modport master (output d, sel, sel_load, mode, en, y_ready,
                  input  y, y_ch, y_last, y_valid);
  modport slave  (input  d, sel, sel_load, mode, en, y_ready,
                  output y, y_ch, y_last, y_valid);
endinterface

// File: rtl/seq_mux.sv
// Registered N-channel sampling mux with manual/auto-scan select and a one-deep
// valid/ready output stage that sustains one sample per cycle.
module seq_mux #(
  parameter int DATA_W = 1,
  parameter int N_CH   = 16,
  parameter int SEL_W  = 4
) (
  input  logic     clk,
  input  logic     rst,
  seq_mux_if.slave bus
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} st_e;

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic [SEL_W-1:0]  ch;
    logic              last;
  } smp_t;

  st_e                         st_q, st_d;
  smp_t                        smp_q, smp_d;
  logic [SEL_W-1:0]            cur_sel_q, cur_sel_d;
  logic [N_CH-1:0][DATA_W-1:0] ch_w;
  logic [DATA_W-1:0]           pick;
  logic                        sample, xfer;

  assign ch_w = bus.d;

  // Explicit compare loop so a non-power-of-two N_CH never indexes past the last channel.
  always_comb begin
    pick = '0;
    for (int k = 0; k < N_CH; k++)
      if (cur_sel_q == SEL_W'(k)) pick = ch_w[k];
  end

  assign xfer   = (st_q == FULL) && bus.y_ready;
  assign sample = bus.en && ((st_q == EMPTY) || bus.y_ready);

  always_comb begin
    st_d      = st_q;
    smp_d     = smp_q;
    cur_sel_d = cur_sel_q;
    unique case (st_q)
      EMPTY: if (sample) st_d = FULL;
      FULL:  if (xfer && !bus.en) st_d = EMPTY;
    endcase
    if (sample) begin
      smp_d.y    = pick;
      smp_d.ch   = cur_sel_q;
      smp_d.last = bus.mode && (cur_sel_q == LAST);
      if (bus.mode) cur_sel_d = (cur_sel_q == LAST) ? '0 : cur_sel_q + SEL_W'(1);
    end
    // A load wins over the scan advance; the sample above already used the old select.
    if (bus.sel_load) cur_sel_d = (32'(bus.sel) >= N_CH) ? '0 : bus.sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= EMPTY;
      smp_q     <= '0;
      cur_sel_q <= '0;
    end else begin
      st_q      <= st_d;
      smp_q     <= smp_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  assign bus.y       = smp_q.y;
  assign bus.y_ch    = smp_q.ch;
  assign bus.y_last  = smp_q.last;
  assign bus.y_valid = (st_q == FULL);
endmodule

// File: tb/tb_seq_mux.sv
// Drives a 16x1 and a 5x8 seq_mux with directed and random stimulus against a cycle reference model.
module tb_seq_mux;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_mux_if #(.DATA_W(1), .N_CH(16), .SEL_W(4)) a_if ();
  seq_mux_if #(.DATA_W(8), .N_CH(5),  .SEL_W(3)) b_if ();

  seq_mux #(.DATA_W(1), .N_CH(16), .SEL_W(4)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  seq_mux #(.DATA_W(8), .N_CH(5),  .SEL_W(3)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the held sample plus the select pointer, advanced by the handshake rules.
  typedef struct {
    int cur;
    bit full;
    int y;
    int ych;
    bit ylast;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t s, int n, int dw, logic [127:0] d, int sel,
                                 bit ld, bit mode, bit en, bit rdy, bit r);
    mdl_t   o;
    bit     take;
    logic [127:0] w;
    o = s;
    if (r) begin
      o = '{cur: 0, full: 0, y: 0, ych: 0, ylast: 0};
      return o;
    end
    take = en && (!s.full || rdy);
    if (s.full && rdy) o.full = 0;
    if (take) begin
      w       = (d >> (s.cur * dw)) & ((128'(1) << dw) - 128'(1));
      o.full  = 1;
      o.y     = int'(w[31:0]);
      o.ych   = s.cur;
      o.ylast = mode && (s.cur == n - 1);
      if (mode) o.cur = (s.cur + 1) % n;
    end
    if (ld) o.cur = (sel >= n) ? 0 : sel;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    ma = mstep(ma, 16, 1, 128'(a_if.d), int'(a_if.sel), a_if.sel_load, a_if.mode,
               a_if.en, a_if.y_ready, rst);
    mb = mstep(mb, 5, 8, 128'(b_if.d), int'(b_if.sel), b_if.sel_load, b_if.mode,
               b_if.en, b_if.y_ready, rst);
    @(negedge clk);
    chk("a_vld", a_if.y_valid, ma.full);
    if (ma.full) begin
      chk("a_y", a_if.y, ma.y);
      chk("a_ch", a_if.y_ch, ma.ych);
      chk("a_last", a_if.y_last, ma.ylast);
    end
    chk("b_vld", b_if.y_valid, mb.full);
    if (mb.full) begin
      chk("b_y", b_if.y, mb.y);
      chk("b_ch", b_if.y_ch, mb.ych);
      chk("b_last", b_if.y_last, mb.ylast);
    end
  endtask

  localparam logic [39:0] RAMP = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};

  initial begin
    ma = '{cur: 0, full: 0, y: 0, ych: 0, ylast: 0};
    mb = ma;
    rst = 1'b1;
    a_if.d = '0; a_if.sel = '0; a_if.sel_load = 0; a_if.mode = 0; a_if.en = 0; a_if.y_ready = 1;
    b_if.d = '0; b_if.sel = '0; b_if.sel_load = 0; b_if.mode = 0; b_if.en = 0; b_if.y_ready = 1;
    tick(); tick();
    chk("rst_vld", b_if.y_valid, 0);
    chk("rst_y", b_if.y, 0);
    chk("rst_ch", b_if.y_ch, 0);
    chk("rst_last", b_if.y_last, 0);
    rst = 1'b0;

    // Manual sweep: only the loaded channel carries a 1.
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) begin
        a_if.d = 16'(1) << k; a_if.sel = 4'(j); a_if.sel_load = 1; a_if.en = 0;
        tick();
        a_if.sel_load = 0; a_if.en = 1;
        tick();
        a_if.en = 0;
        chk("sweep_y", a_if.y, (j == k) ? 1 : 0);
        chk("sweep_ch", a_if.y_ch, j);
        if (k == 2 && j == 2) chk("ch2", a_if.y, 1);
      end
    end

    // Scan over 5 channels of 0x10..0x14.
    b_if.d = RAMP; b_if.mode = 1; b_if.sel = 0; b_if.sel_load = 1; b_if.en = 0;
    tick();
    b_if.sel_load = 0; b_if.en = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("scan_y", b_if.y, 16 + i % 5);
      chk("scan_ch", b_if.y_ch, i % 5);
      chk("scan_last", b_if.y_last, (i % 5 == 4) ? 1 : 0);
    end

    // Backpressure: last scan sample was channel 1 (0x11).
    b_if.y_ready = 0;
    for (int i = 0; i < 3; i++) begin
      b_if.d = 40'({$urandom(), $urandom()});
      tick();
      chk("stall_y", b_if.y, 8'h11);
      chk("stall_ch", b_if.y_ch, 1);
      chk("stall_vld", b_if.y_valid, 1);
    end
    b_if.d = RAMP; b_if.y_ready = 1;
    tick();
    chk("resume_ch", b_if.y_ch, 2);
    chk("resume_y", b_if.y, 8'h12);

    // Out-of-range load falls back to channel 0.
    b_if.en = 0; b_if.sel = 3'd7; b_if.sel_load = 1;
    tick();
    b_if.sel_load = 0; b_if.en = 1;
    tick();
    chk("oor_ch", b_if.y_ch, 0);
    chk("oor_y", b_if.y, 8'h10);

    // Load and scan sample in the same cycle.
    b_if.en = 0; b_if.sel = 3'd3; b_if.sel_load = 1;
    tick();
    b_if.en = 1; b_if.sel = 3'd1; b_if.sel_load = 1;
    tick();
    chk("simul_ch", b_if.y_ch, 3);
    chk("simul_y", b_if.y, 8'h13);
    b_if.sel_load = 0;
    tick();
    chk("simul_next", b_if.y_ch, 1);

    // Reset while holding a stalled sample.
    b_if.en = 0; b_if.y_ready = 0;
    tick();
    chk("pre_rst_vld", b_if.y_valid, 1);
    rst = 1;
    tick();
    rst = 0;
    chk("mid_rst_vld", b_if.y_valid, 0);
    chk("mid_rst_y", b_if.y, 0);
    chk("mid_rst_ch", b_if.y_ch, 0);
    b_if.en = 1; b_if.y_ready = 1;
    tick();
    chk("post_rst_ch", b_if.y_ch, 0);
    chk("post_rst_y", b_if.y, 8'h10);

    // Random traffic on both instances, model-checked every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      a_if.d = 16'($urandom()); a_if.sel = 4'($urandom());
      a_if.sel_load = ($urandom_range(0, 7) == 0); a_if.en = ($urandom_range(0, 3) != 0);
      a_if.y_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) a_if.mode = ~a_if.mode;
      b_if.d = 40'({$urandom(), $urandom()}); b_if.sel = 3'($urandom());
      b_if.sel_load = ($urandom_range(0, 7) == 0); b_if.en = ($urandom_range(0, 3) != 0);
      b_if.y_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) b_if.mode = ~b_if.mode;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
